lstm_cell_state_update: RTL and testbench

Consumer of the controller's `Fun_Cell_EN` / `Hidden_EN` strobes in the LSTM demodulator datapath. It captures the four gate activations on `Fun_Cell_EN`, updates the cell state `c = f*c + i*g` on one time-shared multiplier, and produces the hidden state `h = o*hardtanh(c)` once `Hidden_EN` arrives. It is the responder side of the controller's enable protocol: it checks strobe ordering, flags violations, and counts completed time steps.

---
 rtl/lstm_cell_state_update.sv | 164 ++++++++++++++++
 tb/tb_lstm_cell_state_update.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lstm_cell_state_update.sv
// LSTM cell/hidden state update: c = f*c + i*g, h = o*hardtanh(c) on one shared multiplier.
// Define LSTM_STATE_SAT_EN to saturate c/h results instead of wrapping them.
module lstm_cell_state_update #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12,
  parameter int STEP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     Fun_Cell_EN,
  input  logic                     Hidden_EN,
  input  logic signed [DATA_W-1:0] gate_i,
  input  logic signed [DATA_W-1:0] gate_f,
  input  logic signed [DATA_W-1:0] gate_g,
  input  logic signed [DATA_W-1:0] gate_o,
  output logic signed [DATA_W-1:0] c_state,
  output logic signed [DATA_W-1:0] h_state,
  output logic                     h_valid,
  output logic [STEP_W-1:0]        step_cnt,
  output logic                     busy,
  output logic                     seq_err
);

  localparam int PW = 2 * DATA_W;

  localparam logic signed [DATA_W-1:0] ONE     = DATA_W'(1 << FRAC_W);
  localparam logic signed [DATA_W-1:0] NEG_ONE = -ONE;

`ifdef LSTM_STATE_SAT_EN
  localparam logic signed [PW:0] SAT_MAX = (PW+1)'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [PW:0] SAT_MIN = ~SAT_MAX;
`endif

  typedef enum logic [2:0] {
    IDLE,
    MUL_FC,
    MUL_IG,
    WAIT_H,
    HID
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [DATA_W-1:0] r_gi, r_gf, r_gg, r_go;
  logic signed [DATA_W-1:0] r_c, r_h;
  logic signed [PW-1:0]     r_p1;
  logic [STEP_W-1:0]        r_step;
  logic                     r_hv;
  logic                     r_err;

  logic signed [DATA_W-1:0] w_op_a, w_op_b, w_ht;
  logic signed [PW-1:0]     w_prod, w_shift;
  logic signed [PW:0]       w_sum;
  logic                     w_ld_gates, w_ld_p1, w_ld_c, w_ld_h, w_clr;
  logic                     w_fce_err, w_hen_err;

  function automatic logic signed [DATA_W-1:0] fit(input logic signed [PW:0] v);
`ifdef LSTM_STATE_SAT_EN
    if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return v[DATA_W-1:0];
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (Fun_Cell_EN) w_next = MUL_FC;
      MUL_FC:  w_next = MUL_IG;
      MUL_IG:  w_next = Hidden_EN ? HID : WAIT_H;
      WAIT_H:  if (Hidden_EN) w_next = HID;
      HID:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded controls and protocol checks
  always_comb begin
    busy       = (r_state != IDLE);
    w_ld_gates = (r_state == IDLE) && Fun_Cell_EN;
    w_clr      = (r_state == IDLE) && clear;
    w_ld_p1    = (r_state == MUL_FC);
    w_ld_c     = (r_state == MUL_IG);
    w_ld_h     = (r_state == HID);
    w_fce_err  = Fun_Cell_EN && (r_state != IDLE);
    w_hen_err  = Hidden_EN && ((r_state == IDLE) || (r_state == MUL_FC) || (r_state == HID));
  end

  always_comb begin
    if (r_c > ONE)          w_ht = ONE;
    else if (r_c < NEG_ONE) w_ht = NEG_ONE;
    else                    w_ht = r_c;
  end

  // The single multiplier is steered by state: f*c, then i*g, then o*hardtanh(c)
  always_comb begin
    w_op_a = r_gi;
    w_op_b = r_gg;
    case (r_state)
      MUL_FC:  begin w_op_a = r_gf; w_op_b = r_c;  end
      HID:     begin w_op_a = r_go; w_op_b = w_ht; end
      default: ;
    endcase
  end

  assign w_prod  = PW'(w_op_a) * PW'(w_op_b);
  assign w_shift = w_prod >>> FRAC_W;
  assign w_sum   = (PW+1)'(r_p1) + (PW+1)'(w_shift);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gi   <= '0;
      r_gf   <= '0;
      r_gg   <= '0;
      r_go   <= '0;
      r_p1   <= '0;
      r_c    <= '0;
      r_h    <= '0;
      r_step <= '0;
      r_hv   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_hv <= w_ld_h;
      if (w_clr) begin
        r_c    <= '0;
        r_h    <= '0;
        r_step <= '0;
      end
      if (w_ld_gates) begin
        r_gi <= gate_i;
        r_gf <= gate_f;
        r_gg <= gate_g;
        r_go <= gate_o;
      end
      if (w_ld_p1) r_p1 <= w_shift;
      if (w_ld_c)  r_c  <= fit(w_sum);
      if (w_ld_h) begin
        r_h    <= fit((PW+1)'(w_shift));
        r_step <= r_step + STEP_W'(1);
      end
      // A violation in the same cycle as clear still leaves the flag set
      if (w_clr) r_err <= 1'b0;
      if (w_fce_err || w_hen_err) r_err <= 1'b1;
    end
  end

  assign c_state  = r_c;
  assign h_state  = r_h;
  assign h_valid  = r_hv;
  assign step_cnt = r_step;
  assign seq_err  = r_err;

endmodule

// File: tb/tb_lstm_cell_state_update.sv
// Self-checking bench for lstm_cell_state_update: directed scenarios with literal
// expectations, then randomized strobes/gates compared every cycle to a step-level model.
module tb_lstm_cell_state_update;

  localparam int DW = 16;
  localparam int FW = 12;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst, clear, fce, hen;
  logic signed [DW-1:0] gi, gf, gg, go;
  logic signed [DW-1:0] c_state, h_state;
  logic h_valid, busy, seq_err;
  logic [SW-1:0] step_cnt;

  int checks = 0;
  int errors = 0;

  lstm_cell_state_update #(.DATA_W(DW), .FRAC_W(FW), .STEP_W(SW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .Fun_Cell_EN(fce), .Hidden_EN(hen),
    .gate_i(gi), .gate_f(gf), .gate_g(gg), .gate_o(go),
    .c_state(c_state), .h_state(h_state), .h_valid(h_valid),
    .step_cnt(step_cnt), .busy(busy), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint fit(input longint v);
`ifdef LSTM_STATE_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    shortint s;
    s = shortint'(v);
    return longint'(s);
`endif
  endfunction

  function automatic longint hardtanh(input longint x);
    if (x > 4096) return 4096;
    if (x < -4096) return -4096;
    return x;
  endfunction

  // Step-level model: a step is accepted, c is due two edges later, h one edge after hidden request
  longint m_c = 0, m_h = 0, m_step = 0;
  logic   m_hv = 0, m_err = 0, m_act = 0, m_pend = 0;
  int     m_age = 0;
  longint m_f = 0, m_i = 0, m_g = 0, m_o = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_c <= 0; m_h <= 0; m_step <= 0; m_hv <= 0; m_err <= 0;
      m_act <= 0; m_pend <= 0; m_age <= 0;
    end else begin
      longint c, h, st, f, i, g, o;
      logic hv, er, act, pend;
      int age;
      c = m_c; h = m_h; st = m_step; er = m_err; act = m_act; pend = m_pend; age = m_age;
      f = m_f; i = m_i; g = m_g; o = m_o;
      hv = 0;
      if (!act) begin
        if (clear) begin c = 0; h = 0; st = 0; er = 0; end
        if (hen) er = 1;
        if (fce) begin
          f = gf; i = gi; g = gg; o = go;
          act = 1; age = 0; pend = 0;
        end
      end else begin
        if (fce) er = 1;
        if (pend) begin
          h = fit((o * hardtanh(c)) >>> FW);
          st = (st + 1) % 256;
          hv = 1; act = 0; pend = 0;
          if (hen) er = 1;
        end else begin
          age++;
          if (age == 1) begin
            if (hen) er = 1;
          end else begin
            if (age == 2) c = fit(((f * c) >>> FW) + ((i * g) >>> FW));
            if (hen) pend = 1;
          end
        end
      end
      m_c <= c; m_h <= h; m_step <= st; m_hv <= hv; m_err <= er;
      m_act <= act; m_pend <= pend; m_age <= age;
      m_f <= f; m_i <= i; m_g <= g; m_o <= o;
    end
  end

  always @(negedge clk) begin
    chk("c_state", c_state, m_c);
    chk("h_state", h_state, m_h);
    chk("h_valid", h_valid, m_hv);
    chk("step_cnt", step_cnt, m_step);
    chk("busy", busy, m_act);
    chk("seq_err", seq_err, m_err);
  end

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  // Fun_Cell_EN now, Hidden_EN hdly cycles later; optional stray Fun_Cell_EN one cycle in
  task automatic run_step(input int f, input int i, input int g, input int o,
                          input int hdly, input bit stray);
    gf = 16'(f); gi = 16'(i); gg = 16'(g); go = 16'(o);
    fce = 1;
    for (int k = 1; k <= hdly + 2; k++) begin
      adv();
      if (k == hdly + 1) chk("h_valid_early", h_valid, 0);
      if (k == hdly + 2) chk("h_valid_latency", h_valid, 1);
      if (k == hdly && hdly > 2) chk("wait_h_busy", busy, 1);
      fce = (stray && k == 1);
      if (stray && k == 1) begin gf = 16'(-7000); gi = 16'(9999); gg = 16'(-1234); go = 16'(5); end
      hen = (k == hdly);
    end
    fce = 0; hen = 0;
  endtask

  function automatic logic signed [DW-1:0] rnd_gate();
    int v;
    if ($urandom_range(0, 7) == 0) return 16'($urandom);
    v = int'($urandom_range(0, 16383)) - 8192;
    return 16'(v);
  endfunction

  initial begin
    rst = 1; clear = 0; fce = 0; hen = 0;
    gi = '0; gf = '0; gg = '0; go = '0;
    adv(); adv();
    rst = 0;
    chk("rst_c", c_state, 0); chk("rst_h", h_state, 0); chk("rst_step", step_cnt, 0);
    chk("rst_busy", busy, 0); chk("rst_err", seq_err, 0); chk("rst_hv", h_valid, 0);
    adv();

    run_step(2048, 4096, 2048, 4096, 2, 0);
    chk("nom_c", c_state, 2048); chk("nom_h", h_state, 2048);
    chk("nom_step", step_cnt, 1); chk("nom_err", seq_err, 0);

    run_step(4096, 4096, 4096, 2048, 2, 0);
    chk("clamp_c", c_state, 6144); chk("clamp_h", h_state, 2048); chk("clamp_step", step_cnt, 2);

    run_step(4096, 4096, 26623, 4096, 2, 0);
    chk("max_c", c_state, 32767); chk("max_h", h_state, 4096);

    run_step(4096, 4096, 4096, 4096, 2, 0);
`ifdef LSTM_STATE_SAT_EN
    chk("ovf_c", c_state, 32767);
`else
    chk("ovf_c", c_state, -28673);
`endif

    clear = 1; adv(); clear = 0;
    chk("clear_c", c_state, 0); chk("clear_step", step_cnt, 0);

    run_step(2048, 4096, 2048, 4096, 6, 0);
    chk("late_c", c_state, 2048); chk("late_h", h_state, 2048); chk("late_err", seq_err, 0);

    hen = 1; adv(); hen = 0;
    chk("idle_hen_err", seq_err, 1); chk("idle_hen_h", h_state, 2048);
    clear = 1; adv(); clear = 0;
    chk("clear_err", seq_err, 0);

    run_step(2048, 4096, 2048, 4096, 2, 1);
    chk("stray_c", c_state, 2048); chk("stray_err", seq_err, 1);

    gf = 16'(2048); gi = 16'(4096); gg = 16'(2048); go = 16'(4096);
    fce = 1; adv(); fce = 0; adv();
    rst = 1; #1;
    chk("mid_rst_c", c_state, 0); chk("mid_rst_h", h_state, 0); chk("mid_rst_step", step_cnt, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_err", seq_err, 0); chk("mid_rst_hv", h_valid, 0);
    adv(); rst = 0;
    run_step(2048, 4096, 2048, 4096, 2, 0);
    chk("post_rst_c", c_state, 2048); chk("post_rst_h", h_state, 2048); chk("post_rst_step", step_cnt, 1);

    for (int n = 0; n < 4000; n++) begin
      rst   = ($urandom_range(0, 399) == 0);
      fce   = ($urandom_range(0, 3) == 0);
      hen   = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 15) == 0);
      gi = rnd_gate(); gf = rnd_gate(); gg = rnd_gate(); go = rnd_gate();
      adv();
    end
    rst = 0; fce = 0; hen = 0; clear = 0;
    adv(); adv();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
